// File: rtl/packet_commit_fifo.sv
// Transactional packet FIFO: tentative writes become visible on commit, vanish on rollback.
// Optional registered error pulses are built when PACKET_FIFO_ERR_FLAGS_EN is defined.
module packet_commit_fifo #(
    parameter int WIDTH     = 128,
    parameter int DEPTH     = 512,
    parameter int USE_BLOCK = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_commit,
    input  logic             wr_rollback,
    output logic [AW:0]      wr_size,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_offset,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_pop_single,
    input  logic             rd_pop_packet,
    input  logic [AW:0]      rd_packet_size,
    output logic [AW:0]      rd_size,
    output logic             wr_overflow,
    output logic             rd_underflow
);

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      commit_ptr_q, commit_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] rd_data_q;
    logic [AW:0]      wrPtrInc;
    logic             wrAccept;
    logic [AW-1:0]    wrAddr;
    logic [AW-1:0]    rdAddr;
    logic [WIDTH-1:0] memRdWord;

    assign wr_size  = DEPTH_CNT - (wr_ptr_q - rd_ptr_q);
    assign rd_size  = commit_ptr_q - rd_ptr_q;
    assign rd_data  = rd_data_q;
    assign wrAccept = wr_en && (wr_size != '0);
    assign wrAddr   = wr_ptr_q[AW-1:0];
    assign rdAddr   = rd_ptr_q[AW-1:0] + rd_offset;
    assign wrPtrInc = wr_ptr_q + (AW+1)'(wrAccept);

    // Rollback overrides both the same-cycle write and any commit.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        if (wr_rollback) begin
            wr_ptr_d = commit_ptr_q;
        end else begin
            wr_ptr_d = wrPtrInc;
            if (wr_commit) begin
                commit_ptr_d = wrPtrInc;
            end
        end
        if (rd_pop_packet) begin
            if (rd_packet_size <= rd_size) begin
                rd_ptr_d = rd_ptr_q + rd_packet_size;
            end
        end else if (rd_pop_single) begin
            if (rd_size != '0) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            rd_data_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            if (rd_en) begin
                rd_data_q <= memRdWord;
            end
        end
    end

    // Storage is never reset; only the style hint differs between branches.
    if (USE_BLOCK != 0) begin : g_block_ram
        (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            if (wrAccept) begin
                mem[wrAddr] <= wr_data;
            end
        end
        assign memRdWord = mem[rdAddr];
    end else begin : g_dist_ram
        (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            if (wrAccept) begin
                mem[wrAddr] <= wr_data;
            end
        end
        assign memRdWord = mem[rdAddr];
    end

`ifdef PACKET_FIFO_ERR_FLAGS_EN
    logic wr_overflow_q, rd_underflow_q;
    logic popIgnored;

    assign popIgnored = rd_pop_packet ? (rd_packet_size > rd_size)
                                      : (rd_pop_single && (rd_size == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_overflow_q  <= 1'b0;
            rd_underflow_q <= 1'b0;
        end else begin
            wr_overflow_q  <= wr_en && (wr_size == '0);
            rd_underflow_q <= popIgnored;
        end
    end

    assign wr_overflow  = wr_overflow_q;
    assign rd_underflow = rd_underflow_q;
`else
    assign wr_overflow  = 1'b0;
    assign rd_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_packet_commit_fifo.sv
// Self-checking bench for packet_commit_fifo against a count-based reference model.
// Flag expectations follow PACKET_FIFO_ERR_FLAGS_EN.
module tb_packet_commit_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
`ifdef PACKET_FIFO_ERR_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             wrEn, wrCommit, wrRollback;
    logic [WIDTH-1:0] wrData;
    logic [AW:0]      wrSize;
    logic             rdEn;
    logic [AW-1:0]    rdOffset;
    logic [WIDTH-1:0] rdData;
    logic             popSingle, popPacket;
    logic [AW:0]      packetSize;
    logic [AW:0]      rdSize;
    logic             wrOverflow, rdUnderflow;

    always #5 clk = ~clk;

    packet_commit_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .USE_BLOCK(0)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wrEn), .wr_data(wrData), .wr_commit(wrCommit), .wr_rollback(wrRollback),
        .wr_size(wrSize),
        .rd_en(rdEn), .rd_offset(rdOffset), .rd_data(rdData),
        .rd_pop_single(popSingle), .rd_pop_packet(popPacket), .rd_packet_size(packetSize),
        .rd_size(rdSize), .wr_overflow(wrOverflow), .rd_underflow(rdUnderflow)
    );

    int assertCount = 0;
    int failCount   = 0;

    // Model: word counts plus an unbounded read position; memory indexed modulo DEPTH.
    int               rdBase, comm, tent;
    logic [WIDTH-1:0] modelMem [DEPTH];
    logic [WIDTH-1:0] expRdData;
    bit               expOvf, expUnd;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelStep();
        int  free, popAmt;
        bit  accept;
        if (reset) begin
            rdBase = 0; comm = 0; tent = 0;
            expRdData = '0; expOvf = 0; expUnd = 0;
            return;
        end
        free   = DEPTH - comm - tent;
        accept = wrEn && (free != 0);
        expOvf = wrEn && (free == 0);
        expUnd = 0;
        popAmt = 0;
        if (rdEn) expRdData = modelMem[(rdBase + int'(rdOffset)) % DEPTH];
        if (accept) modelMem[(rdBase + comm + tent) % DEPTH] = wrData;
        if (popPacket) begin
            if (int'(packetSize) <= comm) popAmt = int'(packetSize);
            else expUnd = 1;
        end else if (popSingle) begin
            if (comm != 0) popAmt = 1;
            else expUnd = 1;
        end
        if (wrRollback) begin
            tent = 0;
        end else begin
            tent += int'(accept);
            if (wrCommit) begin
                comm += tent;
                tent = 0;
            end
        end
        comm   -= popAmt;
        rdBase += popAmt;
    endtask

    // One clock: advance the model with the driven inputs, then compare just after the edge.
    task automatic applyStimulus();
        @(posedge clk);
        modelStep();
        #1;
        checkOutput("rdSize", 64'(rdSize), 64'(comm));
        checkOutput("wrSize", 64'(wrSize), 64'(DEPTH - comm - tent));
        checkOutput("rdData", 64'(rdData), 64'(expRdData));
        checkOutput("wrOverflow", 64'(wrOverflow), 64'(FLAGS_EN && expOvf));
        checkOutput("rdUnderflow", 64'(rdUnderflow), 64'(FLAGS_EN && expUnd));
    endtask

    task automatic idle();
        reset = 0; wrEn = 0; wrData = '0; wrCommit = 0; wrRollback = 0;
        rdEn = 0; rdOffset = '0; popSingle = 0; popPacket = 0; packetSize = '0;
    endtask

    task automatic writeWord(input logic [WIDTH-1:0] d, input bit commit);
        idle(); wrEn = 1; wrData = d; wrCommit = commit;
        applyStimulus();
    endtask

    task automatic readWord(input int off, input logic [WIDTH-1:0] want, input string tag);
        idle(); rdEn = 1; rdOffset = off[AW-1:0];
        applyStimulus();
        checkOutput(tag, 64'(rdData), 64'(want));
    endtask

    task automatic popPacketOf(input int n);
        idle(); popPacket = 1; packetSize = n[AW:0];
        applyStimulus();
    endtask

    initial begin
        idle();
        reset = 1;
        applyStimulus();
        applyStimulus();
        checkOutput("resetRdSize", 64'(rdSize), 64'd0);
        checkOutput("resetWrSize", 64'(wrSize), 64'd16);

        // Basic commit and offset reads.
        writeWord(32'hA, 0); writeWord(32'hB, 0); writeWord(32'hC, 0);
        checkOutput("preCommitRdSize", 64'(rdSize), 64'd0);
        idle(); wrCommit = 1; applyStimulus();
        checkOutput("commitRdSize", 64'(rdSize), 64'd3);
        readWord(0, 32'hA, "readA");
        readWord(1, 32'hB, "readB");
        readWord(2, 32'hC, "readC");
        popPacketOf(3);

        // Rollback, then a write committed in the same cycle.
        for (int i = 0; i < 5; i++) writeWord(32'h50 + i, 0);
        checkOutput("tentWrSize", 64'(wrSize), 64'd11);
        idle(); wrRollback = 1; applyStimulus();
        checkOutput("rollbackRdSize", 64'(rdSize), 64'd0);
        checkOutput("rollbackWrSize", 64'(wrSize), 64'd16);
        writeWord(32'hD, 1);
        checkOutput("sameCycleCommit", 64'(rdSize), 64'd1);
        readWord(0, 32'hD, "readD");
        idle(); popSingle = 1; applyStimulus();

        // Full, overflow, whole-buffer packet pop.
        for (int i = 0; i < 16; i++) writeWord(32'h100 + i, i == 15);
        checkOutput("fullWrSize", 64'(wrSize), 64'd0);
        writeWord(32'hDEAD, 0);
        checkOutput("overflowFlag", 64'(wrOverflow), 64'(FLAGS_EN));
        checkOutput("overflowRdSize", 64'(rdSize), 64'd16);
        readWord(15, 32'h10F, "readLastFull");
        popPacketOf(16);
        checkOutput("drainWrSize", 64'(wrSize), 64'd16);
        checkOutput("drainRdSize", 64'(rdSize), 64'd0);

        // Oversized packet pop is ignored.
        for (int i = 0; i < 3; i++) writeWord(32'h200 + i, i == 2);
        popPacketOf(4);
        checkOutput("underflowRdSize", 64'(rdSize), 64'd3);
        checkOutput("underflowFlag", 64'(rdUnderflow), 64'(FLAGS_EN));
        idle(); popSingle = 1; applyStimulus();
        checkOutput("popSingleRdSize", 64'(rdSize), 64'd2);
        readWord(0, 32'h201, "readAfterPop");
        popPacketOf(2);

        // Packets straddling the memory end.
        for (int it = 0; it < 10; it++) begin
            for (int k = 0; k < 7; k++) writeWord(32'h1000 + it * 16 + k, 0);
            idle(); wrCommit = 1; applyStimulus();
            for (int k = 0; k < 7; k++) readWord(k, 32'h1000 + it * 16 + k, "wrapData");
            popPacketOf(7);
        end
        checkOutput("wrapWrSize", 64'(wrSize), 64'd16);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            idle();
            reset      = ($urandom_range(599, 0) == 0);
            wrEn       = ($urandom_range(2, 0) != 0);
            wrData     = $urandom;
            wrCommit   = ($urandom_range(4, 0) == 0);
            wrRollback = ($urandom_range(19, 0) == 0);
            if (comm > 0 && $urandom_range(1, 0) == 1) begin
                rdEn = 1;
                rdOffset = AW'($urandom_range(comm - 1, 0));
            end
            popSingle  = ($urandom_range(3, 0) == 0);
            popPacket  = ($urandom_range(5, 0) == 0);
            packetSize = (AW+1)'($urandom_range(comm + 1, 0));
            applyStimulus();
        end

        // Reset while holding committed and tentative words.
        idle(); reset = 1; applyStimulus();
        for (int i = 0; i < 4; i++) writeWord(32'h300 + i, i == 3);
        writeWord(32'h400, 0); writeWord(32'h401, 0);
        readWord(3, 32'h303, "preResetRead");
        idle(); reset = 1; applyStimulus();
        checkOutput("midResetRdSize", 64'(rdSize), 64'd0);
        checkOutput("midResetWrSize", 64'(wrSize), 64'd16);
        checkOutput("midResetRdData", 64'(rdData), 64'd0);
        idle(); applyStimulus();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
